// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO bus controller.
// Holds the controller state enum, the decoded-region enum, the address
// nibbles that select the peripheral windows and the wait-state limit.
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mio_state_e;

  typedef enum logic [2:0] {
    RGN_RAM  = 3'd0,
    RGN_SW   = 3'd1,
    RGN_LED  = 3'd2,
    RGN_CNT  = 3'd3,
    RGN_NONE = 3'd4
  } mio_region_e;

  // Top address nibble of the switch window and of the LED/counter window.
  localparam logic [3:0] NIB_SW     = 4'hE;
  localparam logic [3:0] NIB_PERIPH = 4'hF;

  // Largest supported number of extra RAM wait cycles (3-bit countdown).
  localparam int unsigned RAM_WAIT_MAX = 7;

  // Map a CPU byte address to the region that serves it. When the counter
  // is not built, its address falls through to the unmapped region.
  function automatic mio_region_e decode_region(input logic [31:0] addr,
                                                input logic        cnt_present);
    mio_region_e rgn;
    rgn = RGN_NONE;
    if (!addr[31]) begin
      rgn = RGN_RAM;
    end else if (addr[31:28] == NIB_SW) begin
      rgn = RGN_SW;
    end else if (addr[31:28] == NIB_PERIPH) begin
      if (!addr[2])         rgn = RGN_LED;
      else if (cnt_present) rgn = RGN_CNT;
      else                  rgn = RGN_NONE;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit counter peripheral. Increments every cycle and wraps
// naturally; a load from the bus takes priority over the increment.
// Only instantiated when MIO_COUNTER_EN is defined.
module mio_counter
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Load has priority; otherwise count up with wrap from all-ones to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the multi-cycle CPU and block RAM plus
// memory-mapped peripherals (LED register, switches, free-running counter).
// A request is taken in IDLE, served in ACCESS (and WAIT for RAM wait
// states), and completed with a one-cycle MIO_ready pulse in DONE.
// Optional feature: define MIO_COUNTER_EN to build the counter peripheral;
// without it the counter address reads 0 and ignores writes.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned RAM_WAIT = 1,
  parameter logic [31:0] LED_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       data_out,
  output logic [31:0]       data_in,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [31:0]       led_out,
  output logic              busy
);

  if (RAM_WAIT > RAM_WAIT_MAX) begin : g_wait_range
    $error("mio_bus_ctrl: RAM_WAIT must be in 0..7");
  end

  localparam logic [2:0] WAIT_CYCLES = 3'(RAM_WAIT);

`ifdef MIO_COUNTER_EN
  localparam logic CNT_PRESENT = 1'b1;
`else
  localparam logic CNT_PRESENT = 1'b0;
`endif

  mio_state_e        state_q,    state_d;
  mio_region_e       region_q,   region_d;
  logic              we_q,       we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       wdata_q,    wdata_d;
  logic [31:0]       rdata_q,    rdata_d;
  logic [31:0]       led_q,      led_d;
  logic [2:0]        wait_q,     wait_d;

`ifdef MIO_COUNTER_EN
  logic        cnt_load;
  logic [31:0] cnt_val;

  mio_counter u_counter (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (wdata_q),
    .count_o    (cnt_val)
  );
`endif

  // Only the region nibble, bit 2 and the word index matter; the rest of
  // the address is intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr_out;

  // Next-state and datapath decisions for one transaction.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d    = state_q;
    region_d   = region_q;
    we_d       = we_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    led_d      = led_q;
    wait_d     = wait_q;
`ifdef MIO_COUNTER_EN
    cnt_load   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (CPU_MIO) begin
          region_d   = decode_region(Addr_out, CNT_PRESENT);
          we_d       = mem_w;
          ram_addr_d = Addr_out[RAM_AW+1:2];
          wdata_d    = data_out;
          rdata_d    = '0;
          state_d    = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        state_d = ST_DONE;
        case (region_q)
          RGN_RAM: begin
            // With no wait states the read data is taken straight away;
            // otherwise the last WAIT cycle takes it.
            if (WAIT_CYCLES == 3'd0) begin
              if (!we_q) rdata_d = ram_dout;
            end else begin
              wait_d  = WAIT_CYCLES;
              state_d = ST_WAIT;
            end
          end
          RGN_SW: begin
            if (!we_q) rdata_d = {16'h0000, sw_in};
          end
          RGN_LED: begin
            if (we_q) led_d   = wdata_q;
            else      rdata_d = led_q;
          end
          RGN_CNT: begin
`ifdef MIO_COUNTER_EN
            if (we_q) cnt_load = 1'b1;
            else      rdata_d  = cnt_val;
`endif
          end
          default: begin
            // Unmapped: reads return the cleared capture, writes vanish.
          end
        endcase
      end

      ST_WAIT: begin
        if (wait_q <= 3'd1) begin
          if (!we_q) rdata_d = ram_dout;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      region_q   <= RGN_NONE;
      we_q       <= 1'b0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      led_q      <= LED_INIT;
      wait_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      region_q   <= region_d;
      we_q       <= we_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      led_q      <= led_d;
      wait_q     <= wait_d;
    end
  end

  // RAM strobes only in ACCESS, so a write can never span two cycles.
  assign ram_we    = (state_q == ST_ACCESS) && (region_q == RGN_RAM) && we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = wdata_q;
  assign MIO_ready = (state_q == ST_DONE);
  assign data_in   = (state_q == ST_DONE) ? rdata_q : 32'h0;
  assign busy      = (state_q != ST_IDLE);
  assign led_out   = led_q;

endmodule

// File: doc/mio_bus_ctrl.md
# mio_bus_ctrl

Memory/IO bus controller that sits directly downstream of the multi-cycle CPU and serves its memory requests. Decodes the CPU address into block RAM or memory-mapped peripherals (LED register, switch input, free-running counter), sequences RAM wait states, and returns read data with a one-cycle `MIO_ready` completion pulse. The CPU control FSM holds in its memory states until that pulse arrives.

## Interface
Parameters:
- `RAM_AW`, 10: RAM word-address width (1024 words).
- `RAM_WAIT`, 1: extra wait cycles for a RAM access, range 0..7.
- `LED_INIT`, 32'h0000_0000: LED register value after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `CPU_MIO` in 1: CPU bus request.
- `mem_w` in 1: 1 = write, 0 = read; sampled with the request.
- `Addr_out` in 32: CPU byte address.
- `data_out` in 32: CPU write data.
- `data_in` out 32: read data to the CPU; valid while `MIO_ready` = 1.
- `MIO_ready` out 1: transaction-complete pulse, one cycle wide.
- `ram_addr` out `RAM_AW`: RAM word address.
- `ram_din` out 32: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_dout` in 32: RAM read data; synchronous, one-cycle latency.
- `sw_in` in 16: switch inputs.
- `led_out` out 32: LED register.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Address map** (`Addr_out[31:28]`):
  - 0x0–0x7: RAM, word index `Addr_out[RAM_AW+1:2]`.
  - 0xE: switch read; returns `{16'h0, sw_in}`.
  - 0xF with `Addr_out[2]` = 0: LED register, read/write.
  - 0xF with `Addr_out[2]` = 1: counter, read/write.
  - All other regions: reads return 0, writes are ignored, and the transaction still completes normally.
- **FSM states:** IDLE, ACCESS, WAIT, DONE.
  - IDLE: when `CPU_MIO` = 1, capture address, write data, `mem_w` and region, then go to ACCESS.
  - ACCESS:
    - RAM: drive `ram_addr`; `ram_we` = `mem_w` for this cycle only. Go to WAIT if `RAM_WAIT` > 0, otherwise DONE.
    - Peripheral: perform the write (or capture the read data), then go to DONE.
  - WAIT: count down `RAM_WAIT` cycles. On the last WAIT cycle, capture `ram_dout` for reads. Then go to DONE.
    - With `RAM_WAIT` = 0, the RAM read data is captured at the end of the ACCESS cycle.
  - DONE: `MIO_ready` = 1 and `data_in` = captured data (0 for writes). Return to IDLE.
- Request inputs are sampled only in IDLE; changes during a transaction are ignored.
- A request still asserted in the IDLE cycle after DONE starts a new transaction. The CPU has already advanced state on `MIO_ready`, so this is its next request.
- **Counter:** 32-bit, increments every cycle and wraps from 0xFFFF_FFFF to 0. A CPU write loads `data_out` and takes priority over the increment in that cycle.
- **Reset** (asynchronous, any time, including mid-transaction):
  - FSM returns to IDLE.
  - `MIO_ready`, `ram_we`, `busy` = 0; `data_in` = 0; `ram_addr` = 0; `ram_din` = 0.
  - `led_out` = `LED_INIT`; counter = 0.
  - An interrupted transaction is dropped and never completes.

## Timing
- A request sampled in IDLE at cycle 0 gives ACCESS at cycle 1.
  - `MIO_ready` at cycle 2 for peripherals or `RAM_WAIT` = 0.
  - `MIO_ready` at cycle 2+`RAM_WAIT` for RAM otherwise.
- Minimum request-to-request spacing is 3 cycles.
- `ram_we` is never high for more than one cycle per transaction.
- `led_out` and the counter update on the clock edge that ends ACCESS.
- A counter read returns the value registered at the end of ACCESS.

## Configuration
- `MIO_COUNTER_EN`:
  - Defined: the counter peripheral is present as described above.
  - Undefined: no counter logic is built; address 0xF…4 behaves as unmapped (reads 0, writes ignored), with the same completion timing.

## Structure
- Package `mio_pkg` holds:
  - the state enum (IDLE, ACCESS, WAIT, DONE);
  - the region enum (RAM, SW, LED, CNT, NONE);
  - the region nibble constants 0xE and 0xF;
  - the `RAM_WAIT` maximum (7).
- Sub-module `mio_counter`: the load/increment counter, instantiated only under `MIO_COUNTER_EN`.

## Test plan
- Write then read RAM, `RAM_WAIT` = 1: write 0xDEADBEEF to 0x0000_0010 → `ram_we` pulses once with `ram_addr` = 4 and `MIO_ready` at cycle 3. Read of the same address → `data_in` = 0xDEADBEEF with `MIO_ready` at cycle 3.
- LED write 0x0000_00A5 to 0xF000_0000 → `led_out` = 0xA5 after ACCESS and `MIO_ready` at cycle 2; a readback returns 0xA5.
- Switch read at 0xE000_0000 with `sw_in` = 0x1234 → `data_in` = 0x0000_1234.
- Counter write 0xFFFF_FFFE, then read 1 cycle after DONE → value has wrapped through 0.
  - Without `MIO_COUNTER_EN`, the same read → 0.
- Unmapped read at 0x9000_0000 → `data_in` = 0, `MIO_ready` at cycle 2, no `ram_we`.
- Reset asserted during WAIT → `MIO_ready` never pulses, `busy` = 0 immediately, `led_out` = `LED_INIT`. After release, a new request completes normally.
